hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Consumes the stage control bits the pipeline controller produces (regwrite/memtoreg per stage, branchD) plus register indices.
- Produces the stall, flush and forwarding controls the datapath and controller consume, including flushE.
- Owns the multi-cycle divider sequencer and merges memory-stall requests.

Parameters:
DIV_CYCLES, 32, divider busy cycles after start (legal range 2..63).

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-low reset
rsD, rtD  input  5  source registers in Decode
rsE, rtE  input  5  source registers in Execute
writeregE, writeregM, writeregW  input  5  destination register per stage
regwriteE, regwriteM, regwriteW  input  1  register-write enable per stage
memtoregE, memtoregM  input  1  load in E / M
branchD  input  1  branch in Decode
divstartE  input  1  div/divu instruction valid in Execute
i_stall  input  1  instruction memory not ready
d_stall  input  1  data memory not ready
forwardaD, forwardbD  output  1  Decode comparator forward from M
forwardaE, forwardbE  output  2  ALU operand select: 00 regfile, 01 W, 10 M
stallF, stallD, stallE, stallM, stallW  output  1  hold the pipeline register of that stage
flushE, flushM  output  1  insert a bubble into E / M
div_busy  output  1  divider running
div_done  output  1  one-cycle pulse; result valid

Behaviour:
- Reset (rst=0, async): FSM goes to IDLE and the counter clears to 0.
  - While in reset, every output is forced to 0.
- Forwarding (combinational). Register 0 never matches.
  - forwardaE = 10 if regwriteM && writeregM==rsE.
  - Otherwise forwardaE = 01 if regwriteW && writeregW==rsE.
  - Otherwise forwardaE = 00.
  - M takes priority over W. forwardbE follows the same rule on rtE.
  - forwardaD = regwriteM && writeregM==rsD. forwardbD is the same on rtD.
- lwstall = memtoregE && regwriteE && writeregE!=0 && (writeregE==rsD || writeregE==rtD).
- brstall = branchD && match on rsD/rtD against either:
  - regwriteE && writeregE; or
  - memtoregM && writeregM.
  - Register 0 is excluded.
- Divider FSM:
  - IDLE: if divstartE && !d_stall, go to BUSY and load counter = DIV_CYCLES-1.
  - BUSY: the counter decrements each cycle. At counter==0 go to DONE.
  - BUSY counts regardless of d_stall.
  - DONE: assert div_done. If !d_stall go to IDLE; otherwise hold DONE with div_done high.
  - divstartE is ignored in BUSY and DONE.
  - div_busy=1 exactly in BUSY.
- Stall priority, highest first:
  1. d_stall: stallF..stallW all 1; flushE=0, flushM=0.
  2. BUSY: stallF=stallD=stallE=1, flushM=1, stallM=stallW=0.
  3. lwstall|brstall: stallF=stallD=1, flushE=1.
  4. i_stall (alone): stallF=stallD=1, flushE=1.
- i_stall combined with tier 2 or 3 yields the union of their stall bits.
- Latency:
  - A div entering E at cycle t holds E during t+1..t+DIV_CYCLES.
  - div_done is high at t+DIV_CYCLES+1.
  - The div leaves E after that cycle.
- A reset mid-divide aborts immediately: IDLE, div_busy=0, no div_done.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, the block adds outputs perf_lw_cnt[31:0] (cycles with lwstall), perf_div_cnt[31:0] (cycles in BUSY) and perf_mem_cnt[31:0] (cycles with d_stall).
  - Counters clear on reset and wrap at 2^32.
  - perf_lw_cnt increments only when tier 3 is the winning stall.
- When undefined, these ports and registers do not exist. Behaviour is otherwise identical.

Test Plan:
- Load-use: memtoregE=1, regwriteE=1, writeregE=8, rsD=8 -> stallF=stallD=flushE=1, all forwards 00.
  - With writeregE=0 instead -> no stall.
- Forwarding: regwriteM=1, writeregM=5, regwriteW=1, writeregW=5, rsE=5 -> forwardaE=10.
  - Drop regwriteM -> forwardaE=01.
  - Set rtE=0 with writeregW=0 -> forwardbE=00.
- Branch: branchD=1, regwriteE=1, writeregE=3, rtD=3 -> stall+flushE.
  - Next cycle, with the instruction in M and memtoregM=0 -> no stall, forwardbD=1.
- Divide, DIV_CYCLES=32: one-cycle divstartE pulse at t -> div_busy high t+1..t+32, stallE high t+1..t+32, flushM high t+1..t+32, div_done high only at t+33.
  - Repeat with DIV_CYCLES=4: div_done at t+5.
- d_stall overlapping DONE: hold d_stall 3 cycles starting when BUSY ends -> div_done held 3 cycles then drops, all five stalls high during d_stall, flushM=0.
- Reset mid-divide: assert rst=0 at t+10 -> all outputs 0 asynchronously.
  - After release, IDLE, no div_done.
  - With HAZARD_PERF_EN: perf_div_cnt reads 0 after reset and 9 just before the reset.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and stall controller for the 5-stage MIPS core, with the multi-cycle divider sequencer.
// Optional build macro HAZARD_PERF_EN adds perf_lw_cnt / perf_div_cnt / perf_mem_cnt stall counters.

// One source operand: forwarding selects plus the raw destination hits used by the stall logic.
module hazard_fwd_lane (
    input  logic [4:0] srcD,
    input  logic [4:0] srcE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteM,
    input  logic       regwriteW,
    output logic       fwdD,
    output logic [1:0] fwdE,
    output logic       hitE,
    output logic       hitM
);
    assign hitE = (writeregE != 5'd0) && (writeregE == srcD);
    assign hitM = (writeregM != 5'd0) && (writeregM == srcD);
    assign fwdD = regwriteM && hitM;

    // M is younger than W, so it wins when both target the same register.
    always_comb begin
        fwdE = 2'b00;
        if (regwriteM && (writeregM != 5'd0) && (writeregM == srcE))
            fwdE = 2'b10;
        else if (regwriteW && (writeregW != 5'd0) && (writeregW == srcE))
            fwdE = 2'b01;
    end
endmodule

module hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       branchD,
    input  logic       divstartE,
    input  logic       i_stall,
    input  logic       d_stall,
    output logic       forwardaD,
    output logic       forwardbD,
    output logic [1:0] forwardaE,
    output logic [1:0] forwardbE,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       stallW,
    output logic       flushE,
    output logic       flushM,
    output logic       div_busy,
    output logic       div_done
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_lw_cnt,
    output logic [31:0] perf_div_cnt,
    output logic [31:0] perf_mem_cnt
`endif
);
    localparam int NUM_OPS = 2;
    localparam int CW      = 6;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} divStateT;

    logic [NUM_OPS-1:0][4:0] srcD, srcE;
    logic [NUM_OPS-1:0][1:0] fwdE;
    logic [NUM_OPS-1:0]      fwdD, hitE, hitM;
    logic                    ldUse, brHaz;
    divStateT                state, nextState;
    logic [CW-1:0]           cnt, cntNext;
    logic                    divBusy, divDone;

    // Operand 0 is rs, operand 1 is rt.
    assign srcD = {rtD, rsD};
    assign srcE = {rtE, rsE};

    for (genvar g = 0; g < NUM_OPS; g++) begin : gLane
        hazard_fwd_lane uLane (
            .srcD      (srcD[g]),
            .srcE      (srcE[g]),
            .writeregE (writeregE),
            .writeregM (writeregM),
            .writeregW (writeregW),
            .regwriteM (regwriteM),
            .regwriteW (regwriteW),
            .fwdD      (fwdD[g]),
            .fwdE      (fwdE[g]),
            .hitE      (hitE[g]),
            .hitM      (hitM[g])
        );
    end

    assign ldUse = memtoregE && regwriteE && (|hitE);
    // The branch comparator sits in D, so an ALU result still in E or a load still in M cannot reach it.
    assign brHaz = branchD && ((regwriteE && (|hitE)) || (memtoregM && (|hitM)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= cntNext;
        end
    end

    // A start is refused under d_stall; once running, the count ignores memory stalls.
    always_comb begin
        nextState = state;
        cntNext   = cnt;
        case (state)
            IDLE: if (divstartE && !d_stall) begin
                nextState = BUSY;
                cntNext   = CNT_LOAD;
            end
            BUSY: if (cnt == '0) nextState = DONE;
                  else           cntNext   = cnt - 1'b1;
            DONE: if (!d_stall) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        divBusy = (state == BUSY);
        divDone = (state == DONE);
    end

    always_comb begin
        forwardaD = 1'b0;
        forwardbD = 1'b0;
        forwardaE = 2'b00;
        forwardbE = 2'b00;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        stallW    = 1'b0;
        flushE    = 1'b0;
        flushM    = 1'b0;
        div_busy  = 1'b0;
        div_done  = 1'b0;
        if (rst) begin
            forwardaD = fwdD[0];
            forwardbD = fwdD[1];
            forwardaE = fwdE[0];
            forwardbE = fwdE[1];
            div_busy  = divBusy;
            div_done  = divDone;
            if (d_stall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                stallW = 1'b1;
            end else begin
                if (divBusy) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    flushM = 1'b1;
                end else if (ldUse || brHaz) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end
                // Never bubble E while it holds the divide.
                if (i_stall) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    if (!divBusy) flushE = 1'b1;
                end
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_lw_cnt  <= '0;
            perf_div_cnt <= '0;
            perf_mem_cnt <= '0;
        end else begin
            if (ldUse && !d_stall && !divBusy) perf_lw_cnt <= perf_lw_cnt + 32'd1;
            if (divBusy)                       perf_div_cnt <= perf_div_cnt + 32'd1;
            if (d_stall)                       perf_mem_cnt <= perf_mem_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (DIV_CYCLES 32 and 4) share stimulus and are checked against a window-based model.
module tb_hazard_ctrl;
    typedef struct packed {
        logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic       rwE, rwM, rwW, mtrE, mtrM, brD, divS, iSt, dSt;
    } inT;

    typedef struct {
        string       name;
        inT          in;
        logic [14:0] exp;
    } vecT;

    localparam int NDIV[2] = '{32, 4};

    logic clk = 1'b0;
    logic rst = 1'b0;
    inT   cur;
    wire [1:0]      fAD, fBD, sF, sD, sE, sM, sW, flE, flM, busy, done;
    wire [1:0][1:0] fAE, fBE;

    int  errors = 0;
    int  checks = 0;
    int  cyc    = 0;
    bit  started[2];
    int  startC[2];
    vecT tbl[$];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : gDut
        hazard_ctrl #(.DIV_CYCLES(NDIV[k])) uDut (
            .clk(clk), .rst(rst),
            .rsD(cur.rsD), .rtD(cur.rtD), .rsE(cur.rsE), .rtE(cur.rtE),
            .writeregE(cur.wE), .writeregM(cur.wM), .writeregW(cur.wW),
            .regwriteE(cur.rwE), .regwriteM(cur.rwM), .regwriteW(cur.rwW),
            .memtoregE(cur.mtrE), .memtoregM(cur.mtrM), .branchD(cur.brD),
            .divstartE(cur.divS), .i_stall(cur.iSt), .d_stall(cur.dSt),
            .forwardaD(fAD[k]), .forwardbD(fBD[k]),
            .forwardaE(fAE[k]), .forwardbE(fBE[k]),
            .stallF(sF[k]), .stallD(sD[k]), .stallE(sE[k]), .stallM(sM[k]), .stallW(sW[k]),
            .flushE(flE[k]), .flushM(flM[k]),
            .div_busy(busy[k]), .div_done(done[k])
        );
    end

    // {fAD, fBD, fAE, fBE, stallF..stallW, flushE, flushM, div_busy, div_done}
    function automatic logic [14:0] outW(int k);
        return {fAD[k], fBD[k], fAE[k], fBE[k], sF[k], sD[k], sE[k], sM[k], sW[k],
                flE[k], flM[k], busy[k], done[k]};
    endfunction

    task automatic check(string nm, logic [14:0] act, logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] mFwdE(inT i, logic [4:0] src);
        if (i.rwM && i.wM != 0 && i.wM == src) return 2'b10;
        if (i.rwW && i.wW != 0 && i.wW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [14:0] mExp(inT i, bit bsy, bit dn);
        bit depE, depM, lw, br, fad, fbd, fle, flm;
        logic [4:0] st;
        depE = i.wE != 0 && (i.wE == i.rsD || i.wE == i.rtD);
        depM = i.wM != 0 && (i.wM == i.rsD || i.wM == i.rtD);
        lw   = i.mtrE && i.rwE && depE;
        br   = i.brD && ((i.rwE && depE) || (i.mtrM && depM));
        fad  = i.rwM && i.wM != 0 && i.wM == i.rsD;
        fbd  = i.rwM && i.wM != 0 && i.wM == i.rtD;
        st = 5'b00000; fle = 0; flm = 0;
        if (i.dSt)                 st = 5'b11111;
        else if (bsy)              begin st = 5'b11100; flm = 1; end
        else if (lw || br || i.iSt) begin st = 5'b11000; fle = 1; end
        return {fad, fbd, mFwdE(i, i.rsE), mFwdE(i, i.rtE), st, fle, flm, bsy, dn};
    endfunction

    // A divide started in cycle s is busy in s+1..s+N and done from s+N+1 until a cycle without d_stall.
    function automatic bit mBusy(int k);
        return started[k] && cyc > startC[k] && cyc <= startC[k] + NDIV[k];
    endfunction

    function automatic bit mDone(int k);
        return started[k] && cyc > startC[k] + NDIV[k];
    endfunction

    task automatic upd();
        for (int k = 0; k < 2; k++) begin
            if (started[k]) begin
                if (mDone(k) && !cur.dSt) started[k] = 0;
            end else if (cur.divS && !cur.dSt) begin
                started[k] = 1;
                startC[k]  = cyc;
            end
        end
        cyc++;
    endtask

    task automatic chkModel(string nm);
        for (int k = 0; k < 2; k++)
            check($sformatf("%s_div%0d", nm, NDIV[k]), outW(k), mExp(cur, mBusy(k), mDone(k)));
    endtask

    task automatic adv();
        @(posedge clk);
        upd();
        #1;
    endtask

    task automatic tick(string nm);
        @(negedge clk);
        chkModel(nm);
        adv();
    endtask

    task automatic waitIdle();
        cur = '0;
        for (int i = 0; i < 100 && (started[0] || started[1]); i++) tick("idle_wait");
    endtask

    function automatic void addV(string n, inT in, logic [14:0] e);
        vecT v;
        v.name = n; v.in = in; v.exp = e;
        tbl.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, doneCnt;

        addV("loaduse",      '{mtrE:1'b1, rwE:1'b1, wE:5'd8, rsD:5'd8, default:'0}, 15'b0_0_00_00_11000_1_0_0_0);
        addV("loaduse_r0",   '{mtrE:1'b1, rwE:1'b1, wE:5'd0, rsD:5'd8, default:'0}, 15'b0);
        addV("loaduse_r0r0", '{mtrE:1'b1, rwE:1'b1, wE:5'd0, rsD:5'd0, default:'0}, 15'b0);
        addV("load_no_rw",   '{mtrE:1'b1, rwE:1'b0, wE:5'd8, rsD:5'd8, default:'0}, 15'b0);
        addV("loaduse_rt_i", '{mtrE:1'b1, rwE:1'b1, wE:5'd9, rtD:5'd9, iSt:1'b1, default:'0}, 15'b0_0_00_00_11000_1_0_0_0);
        addV("fwdA_M",       '{rwM:1'b1, wM:5'd5, rwW:1'b1, wW:5'd5, rsE:5'd5, default:'0}, 15'b0_0_10_00_00000_0_0_0_0);
        addV("fwdA_W",       '{rwM:1'b0, wM:5'd5, rwW:1'b1, wW:5'd5, rsE:5'd5, default:'0}, 15'b0_0_01_00_00000_0_0_0_0);
        addV("fwdB_r0",      '{rwM:1'b1, wM:5'd0, rwW:1'b1, wW:5'd0, default:'0}, 15'b0);
        addV("fwdB_M",       '{rwM:1'b1, wM:5'd7, rwW:1'b1, wW:5'd7, rtE:5'd7, default:'0}, 15'b0_0_00_10_00000_0_0_0_0);
        addV("branch_E",     '{brD:1'b1, rwE:1'b1, wE:5'd3, rtD:5'd3, default:'0}, 15'b0_0_00_00_11000_1_0_0_0);
        addV("branch_Mfwd",  '{brD:1'b1, rwM:1'b1, wM:5'd3, rtD:5'd3, default:'0}, 15'b0_1_00_00_00000_0_0_0_0);
        addV("branch_Mload", '{brD:1'b1, mtrM:1'b1, rwM:1'b1, wM:5'd3, rsD:5'd3, default:'0}, 15'b1_0_00_00_11000_1_0_0_0);
        addV("istall",       '{iSt:1'b1, default:'0}, 15'b0_0_00_00_11000_1_0_0_0);
        addV("dstall",       '{dSt:1'b1, default:'0}, 15'b0_0_00_00_11111_0_0_0_0);
        addV("dstall_lw",    '{dSt:1'b1, mtrE:1'b1, rwE:1'b1, wE:5'd8, rsD:5'd8, iSt:1'b1, default:'0}, 15'b0_0_00_00_11111_0_0_0_0);

        // Reset: everything forced low even with hazards and a divide request present.
        cur = '{rsD:5'd8, wE:5'd8, rwE:1'b1, mtrE:1'b1, iSt:1'b1, dSt:1'b1, divS:1'b1,
                rwM:1'b1, wM:5'd4, rsE:5'd4, default:'0};
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check($sformatf("reset_zero_div%0d", NDIV[k]), outW(k), 15'b0);
        started = '{0, 0};
        cur = '0;
        rst = 1'b1;

        foreach (tbl[i]) begin
            cur = tbl[i].in;
            @(negedge clk);
            for (int k = 0; k < 2; k++) check($sformatf("%s_div%0d", tbl[i].name, NDIV[k]), outW(k), tbl[i].exp);
            adv();
        end

        // Divide latency on both instances from a one-cycle start pulse.
        waitIdle();
        cur.divS = 1'b1;
        t = cyc;
        tick("div_start");
        cur.divS = 1'b0;
        while (cyc <= t + 40) begin
            @(negedge clk);
            chkModel("div_seq");
            check("div32_timing", {11'b0, busy[0], sE[0], flM[0], done[0]},
                  {11'b0, cyc - t >= 1 && cyc - t <= 32, cyc - t >= 1 && cyc - t <= 32,
                   cyc - t >= 1 && cyc - t <= 32, cyc - t == 33});
            check("div4_timing", {13'b0, busy[1], done[1]},
                  {13'b0, cyc - t >= 1 && cyc - t <= 4, cyc - t == 5});
            adv();
        end

        // d_stall over the last busy cycle and into DONE keeps div_done up for exactly three cycles.
        waitIdle();
        cur.divS = 1'b1;
        t = cyc;
        tick("dstall_start");
        cur.divS = 1'b0;
        doneCnt = 0;
        while (cyc <= t + 12) begin
            cur.dSt = (cyc - t >= 4) && (cyc - t <= 6);
            @(negedge clk);
            chkModel("dstall_done");
            if (done[1]) doneCnt++;
            adv();
        end
        check("div4_done_held", 15'(doneCnt), 15'd3);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cur.rsD  = 5'($urandom_range(0, 3));
            cur.rtD  = 5'($urandom_range(0, 3));
            cur.rsE  = 5'($urandom_range(0, 3));
            cur.rtE  = 5'($urandom_range(0, 3));
            cur.wE   = 5'($urandom_range(0, 3));
            cur.wM   = 5'($urandom_range(0, 3));
            cur.wW   = 5'($urandom_range(0, 3));
            cur.rwE  = 1'($urandom_range(0, 1));
            cur.rwM  = 1'($urandom_range(0, 1));
            cur.rwW  = 1'($urandom_range(0, 1));
            cur.mtrE = 1'($urandom_range(0, 1));
            cur.mtrM = 1'($urandom_range(0, 1));
            cur.brD  = 1'($urandom_range(0, 1));
            cur.divS = ($urandom_range(0, 7) == 0);
            cur.iSt  = ($urandom_range(0, 4) == 0);
            cur.dSt  = ($urandom_range(0, 5) == 0);
            tick("rand");
        end

        // Reset ten cycles into a divide aborts it with no div_done afterwards.
        waitIdle();
        cur.divS = 1'b1;
        t = cyc;
        tick("rstdiv_start");
        cur.divS = 1'b0;
        while (cyc < t + 10) tick("rstdiv_busy");
        cur = '{iSt:1'b1, mtrE:1'b1, rwE:1'b1, wE:5'd8, rsD:5'd8, rwM:1'b1, wM:5'd5, rsE:5'd5, default:'0};
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) check($sformatf("async_reset_div%0d", NDIV[k]), outW(k), 15'b0);
        started = '{0, 0};
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check($sformatf("held_reset_div%0d", NDIV[k]), outW(k), 15'b0);
        rst = 1'b1;
        cur = '0;
        repeat (40) begin
            @(negedge clk);
            chkModel("after_reset");
            check("after_reset_nodiv", {11'b0, busy, done}, 15'b0);
            adv();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
